// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// mips_multicycle_control : main control FSM for the multi-cycle MIPS datapath
// Rev 1.0
// ============================================================================
module mips_multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_addi  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC load only in the cycle the fetch actually completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          c_op_rtype:       state_d = S_EXEC_R;
          c_op_lw, c_op_sw: state_d = S_MEM_ADDR;
          c_op_beq:         state_d = S_BRANCH;
          c_op_j:           state_d = S_JUMP;
          c_op_addi:        state_d = S_ADDI_EXEC;
          default:          state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == c_op_lw) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b100;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Outputs are forced quiet for the whole time reset is asserted
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      pc_source     = 2'b00;
      illegal       = 1'b0;
    end

    retired_d = retired_q + CNT_W'(retire);
  end

  assign retired_count = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_mips_multicycle_control : directed self-checking bench for the control FSM
// Rev 1.0
// ============================================================================
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  alu_op;
  logic [31:0] retired_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 32'd0;

  mips_multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal(illegal), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal}
  logic [17:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

  localparam logic [17:0] E_IDLE    = 18'b0;
  localparam logic [17:0] E_FWAIT   = {10'b0001000000, 2'b01, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] E_FRDY    = {10'b1001010000, 2'b01, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] E_DECODE  = {10'b0000000000, 2'b11, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] E_MADDR   = {10'b0000000001, 2'b10, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] E_MREAD   = {10'b0011000000, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] E_MWB     = {10'b0000000110, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] E_MWRITE  = {10'b0010100000, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] E_EXECR   = {10'b0000000001, 2'b00, 3'b100, 2'b00, 1'b0};
  localparam logic [17:0] E_RWB     = {10'b0000001010, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] E_BRANCH  = {10'b0100000001, 2'b00, 3'b001, 2'b01, 1'b0};
  localparam logic [17:0] E_JUMP    = {10'b1000000000, 2'b00, 3'b000, 2'b10, 1'b0};
  localparam logic [17:0] E_ADDIWB  = {10'b0000000010, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] E_TRAP    = {10'b0000000000, 2'b00, 3'b000, 2'b00, 1'b1};

  // Every test task starts at a falling edge with the FSM sitting in FETCH.
  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
    #3;
    n_cmp++;
    if (ctrl !== E_IDLE) begin n_bad++; $display("FAIL reset_outputs: got %b want %b", ctrl, E_IDLE); end
    n_cmp++;
    if (retired_count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %h want 0", retired_count); end
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (ctrl !== E_IDLE) begin n_bad++; $display("FAIL reset_held: got %b want %b", ctrl, E_IDLE); end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [17:0] e [4] = '{E_FRDY, E_DECODE, E_EXECR, E_RWB};
    opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      n_cmp++;
      if (ctrl !== e[i]) begin n_bad++; $display("FAIL rtype_cyc%0d: got %b want %b", i, ctrl, e[i]); end
      if (i == 3) begin
        n_cmp++;
        if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL rtype_count_early: got %h want %h", retired_count, exp_cnt); end
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 1;
    mem_ready = 1'b0; #1;
    n_cmp++;
    if (ctrl !== E_FWAIT) begin n_bad++; $display("FAIL rtype_back_fetch: got %b want %b", ctrl, E_FWAIT); end
    n_cmp++;
    if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL rtype_count: got %h want %h", retired_count, exp_cnt); end
  endtask

  task automatic test_lw_wait();
    logic [17:0] e [8] = '{E_FRDY, E_DECODE, E_MADDR, E_MREAD, E_MREAD, E_MREAD, E_MREAD, E_MWB};
    logic        r [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = r[i]; #1;
      n_cmp++;
      if (ctrl !== e[i]) begin n_bad++; $display("FAIL lw_cyc%0d: got %b want %b", i, ctrl, e[i]); end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 1;
    mem_ready = 1'b0; #1;
    n_cmp++;
    if (ctrl !== E_FWAIT) begin n_bad++; $display("FAIL lw_back_fetch: got %b want %b", ctrl, E_FWAIT); end
    n_cmp++;
    if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL lw_count: got %h want %h", retired_count, exp_cnt); end
  endtask

  task automatic test_sw_fetch_stall();
    logic [17:0] e [10] = '{E_FRDY, E_DECODE, E_MADDR, E_MWRITE,
                            E_FWAIT, E_FWAIT, E_FRDY, E_DECODE, E_MADDR, E_MWRITE};
    logic        r [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 6'b101011;
    for (int i = 0; i < 10; i++) begin
      mem_ready = r[i]; #1;
      n_cmp++;
      if (ctrl !== e[i]) begin n_bad++; $display("FAIL sw_cyc%0d: got %b want %b", i, ctrl, e[i]); end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 2;
    mem_ready = 1'b0; #1;
    n_cmp++;
    if (ctrl !== E_FWAIT) begin n_bad++; $display("FAIL sw_back_fetch: got %b want %b", ctrl, E_FWAIT); end
    n_cmp++;
    if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL sw_count: got %h want %h", retired_count, exp_cnt); end
  endtask

  task automatic test_branch_jump_addi();
    logic [17:0] e [10] = '{E_FRDY, E_DECODE, E_BRANCH, E_FRDY, E_DECODE, E_JUMP,
                            E_FRDY, E_DECODE, E_MADDR, E_ADDIWB};
    logic [5:0]  op [10] = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010,
                             6'b001000, 6'b001000, 6'b001000, 6'b001000};
    for (int i = 0; i < 10; i++) begin
      opcode = op[i]; mem_ready = 1'b1; #1;
      n_cmp++;
      if (ctrl !== e[i]) begin n_bad++; $display("FAIL bja_cyc%0d: got %b want %b", i, ctrl, e[i]); end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 3;
    mem_ready = 1'b0; #1;
    n_cmp++;
    if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL bja_count: got %h want %h", retired_count, exp_cnt); end
  endtask

  task automatic test_illegal();
    logic [17:0] e [4] = '{E_FRDY, E_DECODE, E_TRAP, E_FWAIT};
    logic        r [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i]; #1;
      n_cmp++;
      if (ctrl !== e[i]) begin n_bad++; $display("FAIL illegal_cyc%0d: got %b want %b", i, ctrl, e[i]); end
      if (i < 3) @(negedge clk);
    end
    n_cmp++;
    if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL illegal_count: got %h want %h", retired_count, exp_cnt); end
  endtask

  task automatic test_async_reset();
    logic [17:0] e [4] = '{E_FRDY, E_DECODE, E_MADDR, E_MREAD};
    logic        r [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i]; #1;
      n_cmp++;
      if (ctrl !== e[i]) begin n_bad++; $display("FAIL arst_pre_cyc%0d: got %b want %b", i, ctrl, e[i]); end
      if (i < 3) @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    exp_cnt = 32'd0;
    n_cmp++;
    if (ctrl !== E_IDLE) begin n_bad++; $display("FAIL arst_outputs: got %b want %b", ctrl, E_IDLE); end
    n_cmp++;
    if (retired_count !== 32'd0) begin n_bad++; $display("FAIL arst_count: got %h want 0", retired_count); end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1; #1;
    n_cmp++;
    if (ctrl !== E_FRDY) begin n_bad++; $display("FAIL arst_resume_fetch: got %b want %b", ctrl, E_FRDY); end
    @(negedge clk); #1;
    n_cmp++;
    if (ctrl !== E_DECODE) begin n_bad++; $display("FAIL arst_resume_decode: got %b want %b", ctrl, E_DECODE); end
    @(negedge clk); #1;
    n_cmp++;
    if (ctrl !== E_MADDR) begin n_bad++; $display("FAIL arst_resume_maddr: got %b want %b", ctrl, E_MADDR); end
    @(negedge clk); #1;
    n_cmp++;
    if (ctrl !== E_MREAD) begin n_bad++; $display("FAIL arst_resume_mread: got %b want %b", ctrl, E_MREAD); end
    @(negedge clk); #1;
    n_cmp++;
    if (ctrl !== E_MWB) begin n_bad++; $display("FAIL arst_resume_mwb: got %b want %b", ctrl, E_MWB); end
    @(negedge clk);
    exp_cnt = exp_cnt + 1;
    mem_ready = 1'b0; #1;
    n_cmp++;
    if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL arst_count_after: got %h want %h", retired_count, exp_cnt); end
  endtask

  task automatic test_wrap();
    opcode = 6'b000010;
    mem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++;
    if (ctrl !== E_JUMP) begin n_bad++; $display("FAIL wrap_in_jump: got %b want %b", ctrl, E_JUMP); end
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    #1;
    n_cmp++;
    if (retired_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want ffffffff", retired_count); end
    @(negedge clk);
    mem_ready = 1'b0; #1;
    n_cmp++;
    if (retired_count !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_count: got %h want 00000000", retired_count); end
    n_cmp++;
    if (ctrl !== E_FWAIT) begin n_bad++; $display("FAIL wrap_back_fetch: got %b want %b", ctrl, E_FWAIT); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    @(negedge clk);
    test_sw_fetch_stall();
    @(negedge clk);
    test_branch_jump_addi();
    @(negedge clk);
    test_illegal();
    @(negedge clk);
    test_async_reset();
    @(negedge clk);
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a single unified memory port.
- Drives the 3-bit ALUOp consumed by the ALU control decoder: 000 add, 001 sub, 100 R-type (func decides).
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  instr[31:26] from instruction register.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- iord  output  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  1 selects rd, 0 selects rt.
- mem_to_reg  output  1  1 writes MDR, 0 writes ALUOut.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  0 PC, 1 register A.
- alu_src_b  output  2  00 B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op  output  3  ALUOp to ALU control.
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- illegal  output  1  one-cycle pulse on unsupported opcode.
- retired_count  output  CNT_W  instructions completed.

Behaviour:
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, TRAP.
- Reset:
  - rst_n=0 asynchronously forces state=FETCH and retired_count=0.
  - All outputs are held 0 while rst_n=0, including FETCH's mem_read.
  - Reset mid-instruction abandons the instruction with no retire.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1. These two are Mealy outputs; all others are Moore.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000. Next state by opcode:
  - 000000 -> EXEC_R.
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 001000 (addi) -> ADDI_EXEC.
  - any other opcode -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Goes to MEM_READ if opcode=lw, else MEM_WRITE. Opcode is sampled from the IR each cycle; the IR is stable after FETCH.
- MEM_READ: mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WRITE: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=100. Then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=000. Then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- TRAP: illegal=1 for exactly one cycle, no writes, no retire. Then FETCH.
- Any output not listed for a state is 0.
- Minimum latency with mem_ready tied 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- retired_count:
  - Increments by 1 on the clock edge leaving MEM_WB, R_WB, BRANCH, JUMP or ADDI_WB.
  - Also increments on the edge leaving MEM_WRITE with mem_ready=1.
  - Wraps from 2^CNT_W-1 to 0. A taken or not-taken beq both count.
- mem_write and mem_read are never asserted together. reg_write and any mem request are never asserted together.
- Unreachable state encodings recover to FETCH on the next edge.

Test Plan:
- mem_ready=1, opcode=000000 -> states FETCH, DECODE, EXEC_R, R_WB, FETCH. alu_op=100 in EXEC_R; reg_write=1 and reg_dst=1 in R_WB; retired_count 0->1 after 4 cycles.
- opcode=100011, mem_ready low for 3 cycles in MEM_READ -> mem_read=1 and iord=1 held 4 cycles. MEM_WB asserts reg_write=1 and mem_to_reg=1; total 8 cycles; count+1.
- opcode=101011, mem_ready=1 -> mem_write=1 for exactly 1 cycle with iord=1, reg_write never 1, 4 cycles total. Same with FETCH mem_ready delayed 2 cycles -> ir_write and pc_write pulse only in the ready cycle.
- opcode=000100 then 000010 -> BRANCH gives alu_op=001, pc_write_cond=1, pc_source=01. JUMP gives pc_write=1, pc_source=10. Each takes 3 cycles; count+2.
- opcode=111111 -> illegal=1 for one cycle in TRAP, no reg or mem write, retired_count unchanged, back to FETCH.
- rst_n pulsed low mid-MEM_READ -> all outputs 0 immediately (asynchronous), retired_count=0. FETCH resumes on the first edge after release.
- Preload retired_count to 0xFFFFFFFF via force, retire one instruction -> count=0x00000000.
